// File: rtl/cd_local_reply_dispatch_pkg.sv
// Shared mesh definitions for the local reply dispatcher: header field positions and default quadrant map.
// The optional per-router performance counters are enabled by defining CD_DISPATCH_PERF_EN.
package cd_local_reply_dispatch_pkg;
    localparam int CD_HXO = 55;
    localparam int CD_HXW = 4;
    localparam int CD_HYO = 51;
    localparam int CD_HYW = 4;

    // Default quadrant map: r0=(0,0), r1=(1,0), r2=(0,1), r3=(1,1)
    localparam logic [15:0] CD_RTR_X_DEF = 16'h1010;
    localparam logic [15:0] CD_RTR_Y_DEF = 16'h1100;
endpackage

// File: rtl/cd_rr_arb.sv
// Round-robin arbiter over N requesters; the pointer advances past the winner only when a grant is issued.
module cd_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          found;

    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (en && !found && req[j] && (j == (int'(ptr) + k) % N)) begin
                    grant[j] = 1'b1;
                    ptr_nxt  = PW'((j + 1) % N);
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end
endmodule

// File: rtl/cd_local_reply_dispatch.sv
// Registered local reply dispatcher: decodes Hx/Hy, arbitrates per router, one-entry valid/ready slot per router.
// Define CD_DISPATCH_PERF_EN to add per-router delivery/stall counters (dlv_cnt, stall_cnt).
module cd_local_reply_dispatch
    import cd_local_reply_dispatch_pkg::*;
#(
    parameter int                      DATA_W  = 64,
    parameter int                      NUM_IN  = 2,
    parameter int                      NUM_RTR = 4,
    parameter int                      HXO     = CD_HXO,
    parameter int                      HXW     = CD_HXW,
    parameter int                      HYO     = CD_HYO,
    parameter int                      HYW     = CD_HYW,
    parameter logic [NUM_RTR*HXW-1:0]  RTR_X   = CD_RTR_X_DEF,
    parameter logic [NUM_RTR*HYW-1:0]  RTR_Y   = CD_RTR_Y_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN-1:0]         in_vld,
    output logic [NUM_IN-1:0]         in_rdy,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    output logic [NUM_RTR-1:0]        out_vld,
    input  logic [NUM_RTR-1:0]        out_rdy,
    output logic [NUM_RTR*DATA_W-1:0] out_data,
`ifdef CD_DISPATCH_PERF_EN
    output logic [NUM_RTR*16-1:0]     dlv_cnt,
    output logic [NUM_RTR*16-1:0]     stall_cnt,
`endif
    output logic                      err_miss,
    output logic [7:0]                miss_cnt
);
    localparam int RTR_W = (NUM_RTR > 1) ? $clog2(NUM_RTR) : 1;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] n);
        logic [8:0] s;
        s = {1'b0, a} + {5'd0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [NUM_IN-1:0]                     hit_any;
    logic [NUM_IN-1:0][RTR_W-1:0]          tgt;
    logic [NUM_IN-1:0]                     miss;
    logic [NUM_RTR-1:0][NUM_IN-1:0]        req;
    logic [NUM_RTR-1:0][NUM_IN-1:0]        gnt;
    logic [NUM_RTR-1:0]                    slot_free;
    logic [NUM_RTR-1:0][DATA_W-1:0]        ld_data;
    logic [NUM_IN-1:0]                     gnt_in;
    logic [3:0]                            n_miss;

    logic [NUM_RTR-1:0]                    vld_p1;
    logic [NUM_RTR-1:0][DATA_W-1:0]        data_p1;
    logic                                  err_p1;
    logic [7:0]                            cnt_p1;

    // Stage p0: header decode, lowest matching router wins
    always_comb begin
        hit_any = '0;
        tgt     = '0;
        miss    = '0;
        req     = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            for (int r = NUM_RTR - 1; r >= 0; r--) begin
                if ((in_data[i*DATA_W + HXO - HXW + 1 +: HXW] == RTR_X[r*HXW +: HXW]) &&
                    (in_data[i*DATA_W + HYO - HYW + 1 +: HYW] == RTR_Y[r*HYW +: HYW])) begin
                    hit_any[i] = 1'b1;
                    tgt[i]     = RTR_W'(r);
                end
            end
            miss[i] = in_vld[i] & ~hit_any[i];
            for (int r = 0; r < NUM_RTR; r++) begin
                req[r][i] = in_vld[i] & hit_any[i] & (tgt[i] == RTR_W'(r));
            end
        end
    end

    assign slot_free = ~vld_p1 | out_rdy;

    for (genvar r = 0; r < NUM_RTR; r++) begin : g_arb
        cd_rr_arb #(.N(NUM_IN)) u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (req[r]),
            .en    (slot_free[r] & ~reset),
            .grant (gnt[r])
        );
    end

    always_comb begin
        ld_data = '0;
        gnt_in  = '0;
        n_miss  = '0;
        for (int r = 0; r < NUM_RTR; r++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (gnt[r][i]) begin
                    ld_data[r] = ld_data[r] | in_data[i*DATA_W +: DATA_W];
                    gnt_in[i]  = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (miss[i]) n_miss = n_miss + 4'd1;
        end
    end

    assign in_rdy = reset ? '0 : (gnt_in | miss);

    // Stage p1: per-router output slot and miss bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= '0;
            data_p1 <= '0;
            err_p1  <= 1'b0;
            cnt_p1  <= '0;
        end else begin
            for (int r = 0; r < NUM_RTR; r++) begin
                if (|gnt[r]) begin
                    vld_p1[r]  <= 1'b1;
                    data_p1[r] <= ld_data[r];
                end else if (out_rdy[r]) begin
                    vld_p1[r]  <= 1'b0;
                end
            end
            if (|miss) begin
                err_p1 <= 1'b1;
                cnt_p1 <= sat_add8(cnt_p1, n_miss);
            end
        end
    end

    assign out_vld  = vld_p1;
    assign out_data = data_p1;
    assign err_miss = err_p1;
    assign miss_cnt = cnt_p1;

`ifdef CD_DISPATCH_PERF_EN
    logic [NUM_RTR-1:0][15:0] dlv_p1;
    logic [NUM_RTR-1:0][15:0] stall_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dlv_p1   <= '0;
            stall_p1 <= '0;
        end else begin
            for (int r = 0; r < NUM_RTR; r++) begin
                if (vld_p1[r] && out_rdy[r])  dlv_p1[r]   <= dlv_p1[r] + 16'd1;
                if (vld_p1[r] && !out_rdy[r]) stall_p1[r] <= stall_p1[r] + 16'd1;
            end
        end
    end

    assign dlv_cnt   = dlv_p1;
    assign stall_cnt = stall_p1;
`endif
endmodule

// File: tb/tb_cd_local_reply_dispatch.sv
// Directed self-checking bench for cd_local_reply_dispatch (default 2 inputs, 4 quadrant routers).
module tb_cd_local_reply_dispatch;
    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   in_vld;
    logic [1:0]   in_rdy;
    logic [127:0] in_data;
    logic [3:0]   out_vld;
    logic [3:0]   out_rdy;
    logic [255:0] out_data;
    logic         err_miss;
    logic [7:0]   miss_cnt;
`ifdef CD_DISPATCH_PERF_EN
    logic [63:0]  dlv_cnt;
    logic [63:0]  stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    cd_local_reply_dispatch dut (
        .clk       (clk),
        .reset     (reset),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
`ifdef CD_DISPATCH_PERF_EN
        .dlv_cnt   (dlv_cnt),
        .stall_cnt (stall_cnt),
`endif
        .err_miss  (err_miss),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic [1:0]  c_rdy [4];
    logic [63:0] c_dat [4];

    initial begin
        c_rdy[0] = 2'b01; c_rdy[1] = 2'b10; c_rdy[2] = 2'b01; c_rdy[3] = 2'b10;
        c_dat[0] = 64'h0001_0000_0000_00C0; c_dat[1] = 64'h0001_0000_0000_00C1;
        c_dat[2] = 64'h0001_0000_0000_00C0; c_dat[3] = 64'h0001_0000_0000_00C1;

        reset   = 1'b1;
        in_vld  = 2'b00;
        in_data = '0;
        out_rdy = 4'hF;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_out_vld", 64'(out_vld), 64'h0);
        chk("rst_out_data0", out_data[63:0], 64'h0);
        chk("rst_err_miss", 64'(err_miss), 64'h0);
        chk("rst_miss_cnt", 64'(miss_cnt), 64'h0);
        in_vld = 2'b11;
        #1;
        chk("rst_in_rdy", 64'(in_rdy), 64'h0);
        in_vld = 2'b00;
        reset  = 1'b0;
        tick;

        // Parallel delivery to r1 and r3
        in_data = {64'h0011_0000_0000_00BB, 64'h0010_0000_0000_00AA};
        in_vld  = 2'b11;
        #1;
        chk("par_in_rdy", 64'(in_rdy), 64'h3);
        tick;
        chk("par_out_vld", 64'(out_vld), 64'ha);
        chk("par_data_r1", out_data[127:64], 64'h0010_0000_0000_00AA);
        chk("par_data_r3", out_data[255:192], 64'h0011_0000_0000_00BB);

        // Single miss while slots are held
        out_rdy = 4'h0;
        in_data = {64'h0011_0000_0000_00BB, 64'h0055_0000_0000_00EE};
        in_vld  = 2'b01;
        #1;
        chk("miss_in_rdy", 64'(in_rdy), 64'h1);
        tick;
        chk("miss_out_vld", 64'(out_vld), 64'ha);
        chk("miss_data_r1", out_data[127:64], 64'h0010_0000_0000_00AA);
        chk("miss_err", 64'(err_miss), 64'h1);
        chk("miss_cnt1", 64'(miss_cnt), 64'h1);

        // Build out_vld=0011, then reset asynchronously mid-cycle
        out_rdy = 4'b1010;
        in_data = {64'h0010_0000_0000_0022, 64'h0000_0000_0000_0011};
        in_vld  = 2'b11;
        #1;
        chk("mid_in_rdy", 64'(in_rdy), 64'h3);
        tick;
        chk("mid_out_vld", 64'(out_vld), 64'h3);
        chk("mid_data_r0", out_data[63:0], 64'h0000_0000_0000_0011);
        chk("mid_data_r1", out_data[127:64], 64'h0010_0000_0000_0022);
        in_vld  = 2'b00;
        out_rdy = 4'h0;
        #3;
        reset = 1'b1;
        #1;
        chk("arst_out_vld", 64'(out_vld), 64'h0);
        chk("arst_err_miss", 64'(err_miss), 64'h0);
        chk("arst_miss_cnt", 64'(miss_cnt), 64'h0);
        chk("arst_data_r1", out_data[127:64], 64'h0);
        #2;
        reset = 1'b0;
        tick;

        // Contention for r2: grants alternate
        out_rdy = 4'hF;
        in_data = {64'h0001_0000_0000_00C1, 64'h0001_0000_0000_00C0};
        in_vld  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("cont_in_rdy%0d", k), 64'(in_rdy), 64'(c_rdy[k]));
            tick;
            chk($sformatf("cont_vld%0d", k), 64'(out_vld), 64'h4);
            chk($sformatf("cont_data%0d", k), out_data[191:128], c_dat[k]);
        end
        in_vld = 2'b00;
        tick;
        chk("cont_drain", 64'(out_vld), 64'h0);

        // Backpressure on r0
        out_rdy = 4'b1110;
        in_data = {64'h0, 64'h0000_0000_0000_00D0};
        in_vld  = 2'b01;
        #1;
        chk("bp_in_rdy_free", 64'(in_rdy), 64'h1);
        tick;
        chk("bp_vld_load", 64'(out_vld), 64'h1);
        in_data = {64'h0, 64'h0000_0000_0000_00D1};
        #1;
        chk("bp_in_rdy_stall", 64'(in_rdy), 64'h0);
        tick;
        chk("bp_data_hold", out_data[63:0], 64'h0000_0000_0000_00D0);
        chk("bp_vld_hold", 64'(out_vld), 64'h1);
        out_rdy = 4'hF;
        #1;
        chk("bp_in_rdy_release", 64'(in_rdy), 64'h1);
        tick;
        chk("bp_data_new", out_data[63:0], 64'h0000_0000_0000_00D1);
        chk("bp_vld_new", 64'(out_vld), 64'h1);
        in_vld = 2'b00;
        tick;
        chk("bp_drain", 64'(out_vld), 64'h0);

        // Miss counter saturation: two misses per cycle
        in_data = {64'h0055_0000_0000_0002, 64'h0055_0000_0000_0001};
        in_vld  = 2'b11;
        #1;
        chk("sat_in_rdy", 64'(in_rdy), 64'h3);
        for (int k = 1; k <= 150; k++) begin
            tick;
            if (k == 1)   chk("sat_cnt2", 64'(miss_cnt), 64'd2);
            if (k == 127) chk("sat_cnt254", 64'(miss_cnt), 64'd254);
            if (k == 128) chk("sat_cnt255", 64'(miss_cnt), 64'd255);
        end
        chk("sat_cnt_final", 64'(miss_cnt), 64'hFF);
        chk("sat_err", 64'(err_miss), 64'h1);
        chk("sat_out_vld", 64'(out_vld), 64'h0);
        in_vld = 2'b00;

`ifdef CD_DISPATCH_PERF_EN
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick;
        chk("perf_rst_dlv", 64'(dlv_cnt[15:0]), 64'd0);
        out_rdy = 4'hE;
        in_data = {64'h0, 64'h0000_0000_0000_00F0};
        in_vld  = 2'b01;
        tick;
        in_vld = 2'b00;
        repeat (3) tick;
        out_rdy = 4'hF;
        in_vld  = 2'b01;
        repeat (9) tick;
        in_vld = 2'b00;
        tick;
        chk("perf_dlv0", 64'(dlv_cnt[15:0]), 64'd10);
        chk("perf_stall0", 64'(stall_cnt[15:0]), 64'd3);
        chk("perf_dlv1", 64'(dlv_cnt[31:16]), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
